// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared types and constants for the nibble-serial CLA adder
// Purpose: state encoding, slice width and index-width helper used by
//          cla_chain_sequencer and cla4_slice.
package cla_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble index; never narrower than one bit so WIDTH=4 still
    // gets a legal register.
    function automatic int nib_w(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// rtl/cla4_slice.sv - 4-bit combinational carry-lookahead adder slice
// Purpose: one nibble of a + b + cin using generate/propagate terms and flat
//          lookahead carries (no internal ripple).
// Ports:
//   a[3:0], b[3:0]  nibble operands
//   cin             carry into bit 0
//   s[3:0]          nibble sum
//   cout            carry out of bit 3
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Each carry is a two-level sum of products over g/p and cin.
    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign cout   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    assign s = w_p ^ w_c;

endmodule

// File: rtl/cla_chain_sequencer.sv
// rtl/cla_chain_sequencer.sv - multi-cycle WIDTH-bit adder over one shared 4-bit CLA slice
// Purpose: accepts an add request, processes one nibble per cycle LSB first
//          through a single cla4_slice, carrying between nibbles in a 1-bit
//          register, and presents {cout, sum} with a valid/ready handshake.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake; a, b, cin sampled on accept
//   out_valid/out_ready result handshake; sum, cout held while out_valid
//   busy                high from accept until the result is taken
// WIDTH must be a multiple of 4 and at least 4.
module cla_chain_sequencer
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIB   = WIDTH / SLICE_W;
    localparam int NIB_W = nib_w(NIB);
    localparam logic [NIB_W-1:0] LAST_IDX = NIB_W'(NIB - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [NIB_W-1:0] r_idx;
    logic             r_carry;
    logic             r_cout;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [3:0]       w_nib_a;
    logic [3:0]       w_nib_b;
    logic [3:0]       w_nib_s;
    logic             w_nib_cout;

    // Current nibble picked straight out of the operand registers.
    assign w_nib_a = r_a[r_idx*SLICE_W +: SLICE_W];
    assign w_nib_b = r_b[r_idx*SLICE_W +: SLICE_W];

    cla4_slice u_slice (
        .a    (w_nib_a),
        .b    (w_nib_b),
        .cin  (r_carry),
        .s    (w_nib_s),
        .cout (w_nib_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_busy      <= 1'b0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_carry    <= cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_sum[r_idx*SLICE_W +: SLICE_W] <= w_nib_s;
                    r_carry <= w_nib_cout;
                    if (r_idx == LAST_IDX) begin
                        r_cout      <= w_nib_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    // in_ready returns only after the result has left, so a
                    // request waiting here is taken on the following edge.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign busy      = r_busy;

endmodule

// File: tb/tb_cla_chain_sequencer.sv
// tb/tb_cla_chain_sequencer.sv - self-checking bench for cla_chain_sequencer at WIDTH 4, 16, 32
module tb_cla_chain_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] a, b;
    logic        cin;
    logic [2:0]  in_valid_v;
    logic        out_ready;
    logic [2:0]  in_ready_v, out_valid_v, cout_v, busy_v;
    logic [3:0]  sum4;
    logic [15:0] sum16;
    logic [31:0] sum32;

    cla_chain_sequencer #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a[3:0]), .b(b[3:0]), .cin(cin), .out_valid(out_valid_v[0]),
        .out_ready(out_ready), .sum(sum4), .cout(cout_v[0]), .busy(busy_v[0]));

    cla_chain_sequencer #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a[15:0]), .b(b[15:0]), .cin(cin), .out_valid(out_valid_v[1]),
        .out_ready(out_ready), .sum(sum16), .cout(cout_v[1]), .busy(busy_v[1]));

    cla_chain_sequencer #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid_v[2]),
        .out_ready(out_ready), .sum(sum32), .cout(cout_v[2]), .busy(busy_v[2]));

    int          sel;
    int          cur_w;
    logic [31:0] cur_sum;
    logic        cur_in_ready, cur_out_valid, cur_cout, cur_busy;

    always_comb begin
        cur_in_ready  = in_ready_v[sel];
        cur_out_valid = out_valid_v[sel];
        cur_cout      = cout_v[sel];
        cur_busy      = busy_v[sel];
        case (sel)
            0:       begin cur_sum = {28'd0, sum4};  cur_w = 4;  end
            1:       begin cur_sum = {16'd0, sum16}; cur_w = 16; end
            default: begin cur_sum = sum32;          cur_w = 32; end
        endcase
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: plain integer addition, cout is bit w of the full sum.
    function automatic logic [32:0] ref_add(input int w, input logic [31:0] x,
                                            input logic [31:0] y, input logic c);
        logic [63:0] full;
        logic [63:0] mask;
        logic [63:0] s;
        full = {32'd0, x} + {32'd0, y} + {63'd0, c};
        mask = (64'd1 << w) - 64'd1;
        s    = full & mask;
        return {full[w], s[31:0]};
    endfunction

    task automatic send(input logic [31:0] x, input logic [31:0] y,
                        input logic c, output bit ok);
        int t = 0;
        while (!cur_in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        ok = cur_in_ready;
        a = x; b = y; cin = c;
        in_valid_v = 3'b000;
        in_valid_v[sel] = 1'b1;
        @(negedge clk);
        in_valid_v = 3'b000;
        a = $urandom; b = $urandom; cin = 1'($urandom);
    endtask

    task automatic wait_result(output bit ok, output int lat);
        lat = 0;
        while (!cur_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        ok = cur_out_valid;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        bit seen;
        sel = 1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_tests++; if (cur_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", cur_in_ready); end
        n_tests++; if (cur_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", cur_out_valid); end
        n_tests++; if (cur_sum !== 32'd0 || cur_cout !== 1'b0) begin n_fail++; $display("FAIL rst_sum: got %h/%b want 0/0", cur_sum, cur_cout); end
        n_tests++; if (cur_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", cur_busy); end
        send(32'hABCD, 32'h1111, 1'b1, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rst_accept: got in_ready 0 want 1"); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (cur_in_ready !== 1'b1 || cur_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_hs: got ready %b valid %b want 1 0", cur_in_ready, cur_out_valid); end
        n_tests++; if (cur_sum !== 32'd0 || cur_cout !== 1'b0 || cur_busy !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_state: got sum %h cout %b busy %b want 0 0 0", cur_sum, cur_cout, cur_busy); end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (cur_out_valid) seen = 1'b1;
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_no_result: got out_valid pulse want none"); end
    endtask

    task automatic test_basic();
        bit ok; int lat;
        sel = 1;
        send(32'h1234, 32'h4321, 1'b0, ok);
        wait_result(ok, lat);
        n_tests++; if (!ok || lat != 4) begin n_fail++; $display("FAIL basic_latency: got %0d want 4", lat); end
        n_tests++; if (cur_sum !== 32'h5555 || cur_cout !== 1'b0) begin n_fail++; $display("FAIL basic_sum: got %h/%b want 5555/0", cur_sum, cur_cout); end
        handshake();
        n_tests++; if (cur_out_valid !== 1'b0 || cur_in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_release: got valid %b ready %b want 0 1", cur_out_valid, cur_in_ready); end
    endtask

    task automatic test_ripple();
        bit ok; int lat;
        sel = 1;
        send(32'hFFFF, 32'h0000, 1'b1, ok);
        wait_result(ok, lat);
        n_tests++; if (!ok || cur_sum !== 32'h0000 || cur_cout !== 1'b1) begin n_fail++; $display("FAIL ripple: got %h/%b want 0000/1", cur_sum, cur_cout); end
        handshake();
    endtask

    task automatic test_backpressure();
        bit ok; int lat;
        logic [32:0] exp1;
        sel = 1;
        exp1 = ref_add(16, 32'h0F0F, 32'h0101, 1'b0);
        send(32'h0F0F, 32'h0101, 1'b0, ok);
        wait_result(ok, lat);
        in_valid_v[1] = 1'b1;
        a = 32'h2222; b = 32'h3333; cin = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++; if ({cur_cout, cur_sum} !== exp1 || cur_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got %b_%h valid %b want %h valid 1", cur_cout, cur_sum, cur_out_valid, exp1); end
            n_tests++; if (cur_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", cur_in_ready); end
        end
        handshake();
        n_tests++; if (cur_in_ready !== 1'b1 || cur_busy !== 1'b0) begin n_fail++; $display("FAIL bp_after_hs: got ready %b busy %b want 1 0", cur_in_ready, cur_busy); end
        @(negedge clk);
        in_valid_v = 3'b000;
        n_tests++; if (cur_busy !== 1'b1 || cur_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept: got busy %b ready %b want 1 0", cur_busy, cur_in_ready); end
        wait_result(ok, lat);
        n_tests++; if (!ok || lat != 4 || cur_sum !== 32'h5556 || cur_cout !== 1'b0) begin n_fail++; $display("FAIL bp_second: got %h/%b lat %0d want 5556/0 lat 4", cur_sum, cur_cout, lat); end
        handshake();
    endtask

    task automatic test_back_to_back();
        bit ok; int lat;
        sel = 1;
        out_ready = 1'b1;
        send(32'h8000, 32'h8000, 1'b0, ok);
        wait_result(ok, lat);
        n_tests++; if (!ok || cur_sum !== 32'h0000 || cur_cout !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got %h/%b want 0000/1", cur_sum, cur_cout); end
        @(negedge clk);
        n_tests++; if (cur_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", cur_in_ready); end
        send(32'h00FF, 32'h0001, 1'b0, ok);
        wait_result(ok, lat);
        n_tests++; if (!ok || lat != 4 || cur_sum !== 32'h0100 || cur_cout !== 1'b0) begin n_fail++; $display("FAIL b2b_second: got %h/%b lat %0d want 0100/0 lat 4", cur_sum, cur_cout, lat); end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_random(input int s, input int n);
        bit ok; int lat; int t;
        logic [31:0] x, y, mask;
        logic c, done;
        logic [32:0] exp;
        sel = s;
        @(negedge clk);
        mask = (cur_w == 32) ? 32'hFFFF_FFFF : ((32'd1 << cur_w) - 32'd1);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            x = $urandom & mask;
            y = $urandom & mask;
            c = 1'($urandom);
            if (i % 7 == 0) begin x = mask; y = 32'd0; c = 1'b1; end
            exp = ref_add(cur_w, x, y, c);
            send(x, y, c, ok);
            lat = 0;
            while (!cur_out_valid && lat < 100) begin
                out_ready = 1'($urandom);
                @(negedge clk);
                lat++;
            end
            n_tests++; if (!ok || lat != cur_w / 4) begin n_fail++; $display("FAIL rand_latency w%0d: got %0d want %0d", cur_w, lat, cur_w / 4); end
            done = 1'b0;
            t = 0;
            while (!done && t < 50) begin
                out_ready = ($urandom_range(0, 2) != 0);
                if (out_ready) begin
                    n_tests++; if (cur_out_valid !== 1'b1 || {cur_cout, cur_sum} !== exp) begin n_fail++; $display("FAIL rand_sum w%0d: got %b_%h want %h (a=%h b=%h c=%b)", cur_w, cur_cout, cur_sum, exp, x, y, c); end
                    done = 1'b1;
                end
                @(negedge clk);
                t++;
            end
            out_ready = 1'b0;
            n_tests++; if (!done) begin n_fail++; $display("FAIL rand_handshake w%0d: got no handshake want one", cur_w); end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid_v = 3'b000;
        out_ready = 1'b0;
        a = 32'd0; b = 32'd0; cin = 1'b0;
        sel = 1;
        test_reset();
        test_basic();
        test_ripple();
        test_backpressure();
        test_back_to_back();
        test_random(0, 1000);
        test_random(1, 1000);
        test_random(2, 1000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
